// File: rtl/cnn_pkg.sv
// cnn_pkg: helpers shared by the CNN pipeline stages (convolution_stage,
// max_pool_stage): beat-width derivation, signed lane max and the default
// pixel beat type.
package cnn_pkg;

   localparam int CNN_NUM_K    = 4;
   localparam int CNN_BIT_SIZE = 4;
   localparam int CNN_CPP      = 2;

   // Channels carried per beat: ceil(num_k / cpp).
   function automatic int pe_count(input int num_k, input int cpp);
      return (num_k + cpp - 1) / cpp;
   endfunction

   localparam int CNN_PE = pe_count(CNN_NUM_K, CNN_CPP);

   // One channel value and one beat of channels for the default configuration.
   typedef logic signed [CNN_BIT_SIZE-1:0] lane_t;
   typedef lane_t [CNN_PE-1:0] pixel_beat_t;

   // Signed max of two lanes. Callers sign-extend narrower lanes into the
   // 32-bit operands and truncate the result back to their own width, so one
   // function serves every BitSize.
   function automatic logic signed [31:0] lane_max(input logic signed [31:0] a,
                                                   input logic signed [31:0] b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/pool_line_buffer.sv
// pool_line_buffer: one half-width row of partial maxima for the pooling stage.
// One write port and one combinational read port; the entry address is
// {col/2, beat}, i.e. (col/2)*CyclesPerPixel + beat, formed by the caller.
module pool_line_buffer
   import cnn_pkg::*;
#(
   parameter int Depth = 1,
   parameter int Width = 8,
   localparam int AddrW = (Depth > 1) ? $clog2(Depth) : 1
) (
   input  logic             clk,
   input  logic             wr_en,
   input  logic [AddrW-1:0] wr_addr,
   input  logic [Width-1:0] wr_data,
   input  logic [AddrW-1:0] rd_addr,
   output logic [Width-1:0] rd_data
);

   logic [Width-1:0] mem [Depth];

   // Storage write; contents are never reset because every read of an entry
   // within a frame is preceded by a write to it from the even row above.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   // The odd-row even-column beat merges the stored partial max in the same
   // cycle it arrives, so the read is combinational.
   assign rd_data = mem[rd_addr];

endmodule

// File: rtl/max_pool_stage.sv
// max_pool_stage: 2x2, stride-2 signed max pooling over the multi-beat channel
// stream produced by convolution_stage. Pixels arrive in raster order, each as
// CyclesPerPixel beats of ProcessingElements channels; pooled pixels leave in
// the same beat format at half resolution.
//
// Optional build macro MAX_POOL_RELU_EN: when defined every pooled lane is
// clamped to max(x, 0); when undefined the signed max is passed unchanged.
//
// Handshake: a beat moves on a channel when valid && ready are both high at a
// rising clock edge. valid never depends on ready and, once raised, is held
// with stable data until the beat is taken. in_ready = !out_valid || out_ready,
// so the output register may drain and reload in the same cycle.
module max_pool_stage
   import cnn_pkg::*;
#(
   parameter int NumberOfK      = 4,
   parameter int BitSize        = 4,
   parameter int InWidth        = 2,
   parameter int InHeight       = 2,
   parameter int CyclesPerPixel = 2,
   localparam int ProcessingElements = pe_count(NumberOfK, CyclesPerPixel)
) (
   input  logic                                 clk,
   input  logic                                 res,
   input  logic                                 in_valid,
   output logic                                 in_ready,
   input  logic [ProcessingElements*BitSize-1:0] in_data,
   output logic                                 out_valid,
   input  logic                                 out_ready,
   output logic [ProcessingElements*BitSize-1:0] out_data,
   output logic                                 out_done
);

   localparam int PE         = ProcessingElements;
   localparam int BeatW      = (CyclesPerPixel > 1) ? $clog2(CyclesPerPixel) : 1;
   localparam int ColW       = (InWidth > 1) ? $clog2(InWidth) : 1;
   localparam int RowW       = (InHeight > 1) ? $clog2(InHeight) : 1;
   localparam int LbDepth    = ((InWidth / 2) > 0) ? (InWidth / 2) * CyclesPerPixel : 1;
   localparam int LbAddrW    = (LbDepth > 1) ? $clog2(LbDepth) : 1;
   // Last row/column that closes a 2x2 window (odd dimensions round down).
   localparam int LastOddRow = (InHeight / 2) * 2 - 1;
   localparam int LastOddCol = (InWidth / 2) * 2 - 1;
   // An odd dimension leaves a trailing row/column that is consumed unused.
   localparam bit ColDropEn  = (InWidth % 2) == 1;
   localparam bit RowDropEn  = (InHeight % 2) == 1;

   typedef logic [BitSize-1:0] lane_bits_t;
   typedef lane_bits_t [PE-1:0] beat_t;

   // Lane-wise signed max of two beats, no widening.
   function automatic beat_t beat_max(input beat_t a, input beat_t b);
      beat_t r;
      for (int i = 0; i < PE; i++) begin
         r[i] = BitSize'(lane_max(32'(signed'(a[i])), 32'(signed'(b[i]))));
      end
      return r;
   endfunction

   // Final pooled value for one output beat.
   function automatic beat_t pool_result(input beat_t a, input beat_t b);
      beat_t r;
      r = beat_max(a, b);
`ifdef MAX_POOL_RELU_EN
      for (int i = 0; i < PE; i++) begin
         if (r[i][BitSize-1]) begin
            r[i] = '0;
         end
      end
`endif
      return r;
   endfunction

   // Raster position of the beat currently offered on the input.
   logic [BeatW-1:0]   beat;
   logic [ColW-1:0]    col;
   logic [RowW-1:0]    row;

   logic               hs;
   logic               beat_last;
   logic               col_last;
   logic               row_last;
   logic               col_drop;
   logic               row_drop;
   logic               col_odd;
   logic               row_odd;
   logic               frame_last;

   beat_t              in_beat;
   beat_t              pair_reg [CyclesPerPixel];
   beat_t              pair_next;
   logic               load_pair;
   logic               load_out;
   beat_t              out_next;

   logic               lb_we;
   logic [LbAddrW-1:0] lb_addr;
   beat_t              lb_wr;
   beat_t              lb_rd;

   assign in_beat  = in_data;
   assign in_ready = !out_valid || out_ready;
   assign hs       = in_valid && in_ready;

   // Position decode: wrap points, discarded trailing row/column, frame end.
   always_comb begin
      beat_last  = (beat == BeatW'(CyclesPerPixel - 1));
      col_last   = (col == ColW'(InWidth - 1));
      row_last   = (row == RowW'(InHeight - 1));
      col_drop   = ColDropEn && col_last;
      row_drop   = RowDropEn && row_last;
      col_odd    = col[0];
      row_odd    = row[0];
      frame_last = (int'(row) == LastOddRow) && (int'(col) == LastOddCol) && beat_last;
   end

   // Pooling datapath: pick which storage the accepted beat updates.
   //   even row, even col : pair <= in
   //   even row, odd col  : linebuf <= max(pair, in)
   //   odd row,  even col : pair <= max(linebuf, in)
   //   odd row,  odd col  : output <= max(pair, in)
   always_comb begin
      lb_addr   = LbAddrW'(int'(col >> 1) * CyclesPerPixel + int'(beat));
      lb_we     = 1'b0;
      lb_wr     = beat_max(pair_reg[beat], in_beat);
      load_pair = 1'b0;
      pair_next = in_beat;
      load_out  = 1'b0;
      out_next  = pool_result(pair_reg[beat], in_beat);
      if (hs && !col_drop && !row_drop) begin
         if (!row_odd) begin
            if (!col_odd) begin
               load_pair = 1'b1;
            end else begin
               lb_we = 1'b1;
            end
         end else begin
            if (!col_odd) begin
               load_pair = 1'b1;
               pair_next = beat_max(lb_rd, in_beat);
            end else begin
               load_out = 1'b1;
            end
         end
      end
   end

   // Beat/column/row counters; they move only on an accepted input beat.
   always_ff @(posedge clk) begin
      if (res) begin
         beat <= '0;
         col  <= '0;
         row  <= '0;
      end else if (hs) begin
         if (beat_last) begin
            beat <= '0;
            if (col_last) begin
               col <= '0;
               row <= row_last ? '0 : row + 1'b1;
            end else begin
               col <= col + 1'b1;
            end
         end else begin
            beat <= beat + 1'b1;
         end
      end
   end

   // Pair register, one slot per beat; not reset since it is always written
   // at the even column before the odd column reads it.
   always_ff @(posedge clk) begin
      if (load_pair) begin
         pair_reg[beat] <= pair_next;
      end
   end

   // Output register: load on a producing beat, otherwise hold until taken.
   always_ff @(posedge clk) begin
      if (res) begin
         out_valid <= 1'b0;
         out_done  <= 1'b0;
         out_data  <= '0;
      end else if (load_out) begin
         out_valid <= 1'b1;
         out_done  <= frame_last;
         out_data  <= out_next;
      end else if (out_ready) begin
         out_valid <= 1'b0;
         out_done  <= 1'b0;
      end
   end

   pool_line_buffer #(
      .Depth (LbDepth),
      .Width (PE * BitSize)
   ) u_line_buffer (
      .clk     (clk),
      .wr_en   (lb_we),
      .wr_addr (lb_addr),
      .wr_data (lb_wr),
      .rd_addr (lb_addr),
      .rd_data (lb_rd)
   );

endmodule

// File: tb/tb_max_pool_stage.sv
// tb_max_pool_stage: directed bench for max_pool_stage with three instances
// (2x2, 4x4 and 3x3 feature maps; 4 channels, 2 beats per pixel, 4-bit data).
// Expected pooled pixels are hand-computed and queued; a monitor pops one per
// output handshake and compares data and out_done.
module tb_max_pool_stage;

   localparam int W = 8;

`ifdef MAX_POOL_RELU_EN
   localparam int ReluExp = 0;
`else
   localparam int ReluExp = -2;
`endif

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic res;
   always #5 clk = ~clk;

   logic         in_valid  [3];
   logic         in_ready  [3];
   logic [W-1:0] in_data   [3];
   logic         out_valid [3];
   logic         out_ready [3];
   logic [W-1:0] out_data  [3];
   logic         out_done  [3];

   // Scoreboard entries: {dut index, out_done, out_data}.
   logic [10:0] exp_q [$];
   int total = 0;
   int bad   = 0;

   int ch0_4x4 [16] = '{1, 2, 3, 4, 5, -1, 0, 7, -8, -8, -2, -3, -4, -5, -6, -1};
   logic [W-1:0] b4 [32];

   max_pool_stage #(.NumberOfK(4), .BitSize(4), .InWidth(2), .InHeight(2), .CyclesPerPixel(2)) dut_2x2 (
      .clk(clk), .res(res),
      .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data[0]),
      .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_data(out_data[0]), .out_done(out_done[0])
   );

   max_pool_stage #(.NumberOfK(4), .BitSize(4), .InWidth(4), .InHeight(4), .CyclesPerPixel(2)) dut_4x4 (
      .clk(clk), .res(res),
      .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data[1]),
      .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_data(out_data[1]), .out_done(out_done[1])
   );

   max_pool_stage #(.NumberOfK(4), .BitSize(4), .InWidth(3), .InHeight(3), .CyclesPerPixel(2)) dut_3x3 (
      .clk(clk), .res(res),
      .in_valid(in_valid[2]), .in_ready(in_ready[2]), .in_data(in_data[2]),
      .out_valid(out_valid[2]), .out_ready(out_ready[2]), .out_data(out_data[2]), .out_done(out_done[2])
   );

   // ---------------- helpers ----------------
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Beat with the lower-numbered channel in the low nibble.
   function automatic logic [W-1:0] px_beat(input int lo, input int hi);
      logic [3:0] l;
      logic [3:0] h;
      l = 4'(lo);
      h = 4'(hi);
      return {h, l};
   endfunction

   // ---------------- driver tasks ----------------
   // Called at a falling edge; returns at the falling edge after the handshake.
   task automatic send_beat(input int d, input logic [W-1:0] data);
      int n;
      n = 0;
      in_valid[d] = 1'b1;
      in_data[d]  = data;
      #1;
      while (in_ready[d] !== 1'b1 && n < 50) begin
         @(negedge clk);
         #1;
         n++;
      end
      check("send_timeout", 32'(n < 50), 1);
      @(negedge clk);
      in_valid[d] = 1'b0;
   endtask

   task automatic send_px(input int d, input int c0, input int c1, input int c2, input int c3);
      send_beat(d, px_beat(c0, c1));
      send_beat(d, px_beat(c2, c3));
   endtask

   task automatic expect_px(input int d, input int c0, input int c1, input int c2, input int c3,
                            input logic done);
      exp_q.push_back({2'(d), 1'b0, px_beat(c0, c1)});
      exp_q.push_back({2'(d), done, px_beat(c2, c3)});
   endtask

   task automatic drain(input string tag);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 40) begin
         @(negedge clk);
         #3;
         n++;
      end
      check(tag, 32'(exp_q.size()), 0);
      @(negedge clk);
   endtask

   task automatic expect_4x4(input logic dummy);
      expect_px(1, 5, 3, -1, 1, dummy);
      expect_px(1, 7, 6, -1, 3, 1'b0);
      expect_px(1, -4, 3, -1, 1, 1'b0);
      expect_px(1, -1, 3, -1, 3, 1'b1);
   endtask

   // ---------------- scoreboard monitor ----------------
   // Samples between the driving falling edge and the next rising edge.
   initial begin : monitor
      logic [10:0] obs;
      logic [10:0] want;
      forever begin
         @(negedge clk);
         #2;
         for (int d = 0; d < 3; d++) begin
            if (out_valid[d] === 1'b1 && out_ready[d] === 1'b1) begin
               check("beat_expected", 32'(exp_q.size() != 0), 1);
               if (exp_q.size() != 0) begin
                  want = exp_q.pop_front();
                  obs  = {2'(d), out_done[d], out_data[d]};
                  check("out_beat", 32'(obs), 32'(want));
               end
            end
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: bench did not finish in time");
      $fatal(1, "watchdog expired");
   end

   // ---------------- directed sequence ----------------
   initial begin : stimulus
      res = 1'b1;
      for (int d = 0; d < 3; d++) begin
         in_valid[d]  = 1'b0;
         in_data[d]   = '0;
         out_ready[d] = 1'b1;
      end
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < 4; c++) begin
            b4[(r*4+c)*2]     = px_beat(ch0_4x4[r*4+c], (r == 1 && c == 2) ? 6 : 3);
            b4[(r*4+c)*2 + 1] = px_beat(-1, c);
         end
      end
      repeat (2) @(negedge clk);
      res = 1'b0;
      #1;
      for (int d = 0; d < 3; d++) begin
         check("rst_out_valid", 32'(out_valid[d]), 0);
         check("rst_out_done", 32'(out_done[d]), 0);
         check("rst_out_data", 32'(out_data[d]), 0);
         check("rst_in_ready", 32'(in_ready[d]), 1);
      end
      @(negedge clk);

      // Single 2x2 window: channels max to {5, 4, -1, 7}.
      expect_px(0, 5, 4, -1, 7, 1'b1);
      send_px(0, 1, 0, -1, 7);
      send_px(0, -3, 4, -2, -8);
      send_px(0, 5, -7, -6, 3);
      #1;
      check("t1_no_early_valid", 32'(out_valid[0]), 0);
      send_beat(0, px_beat(2, -1));
      #1;
      check("t1_latency_valid", 32'(out_valid[0]), 1);
      check("t1_latency_data", 32'(out_data[0]), 32'h45);
      check("t1_done_low_beat0", 32'(out_done[0]), 0);
      send_beat(0, px_beat(-5, -4));
      drain("t1_drain");

      // 4x4 map, free-flowing output.
      expect_4x4(1'b0);
      for (int i = 0; i < 32; i++) send_beat(1, b4[i]);
      drain("t2_drain");

      // Same map with the first output held off for three cycles.
      expect_4x4(1'b0);
      out_ready[1] = 1'b0;
      for (int i = 0; i < 11; i++) send_beat(1, b4[i]);
      #1;
      check("bp_valid", 32'(out_valid[1]), 1);
      check("bp_data", 32'(out_data[1]), 32'h35);
      in_valid[1] = 1'b1;
      in_data[1]  = b4[11];
      for (int k = 0; k < 3; k++) begin
         #1;
         check("bp_hold_valid", 32'(out_valid[1]), 1);
         check("bp_hold_data", 32'(out_data[1]), 32'h35);
         check("bp_in_ready_low", 32'(in_ready[1]), 0);
         @(negedge clk);
      end
      out_ready[1] = 1'b1;
      for (int i = 11; i < 32; i++) send_beat(1, b4[i]);
      drain("t3_drain");

      // Abandon a frame after 5 beats, reset, then run a clean frame.
      for (int i = 0; i < 5; i++) send_beat(1, 8'h77);
      res = 1'b1;
      @(negedge clk);
      res = 1'b0;
      #1;
      check("mid_rst_out_valid", 32'(out_valid[1]), 0);
      check("mid_rst_out_data", 32'(out_data[1]), 0);
      check("mid_rst_out_done", 32'(out_done[1]), 0);
      check("mid_rst_in_ready", 32'(in_ready[1]), 1);
      @(negedge clk);
      expect_4x4(1'b0);
      for (int i = 0; i < 32; i++) send_beat(1, b4[i]);
      drain("t5_drain");

      // 3x3 map: only the top-left window is pooled -> {0, 1, -8, 0}.
      expect_px(2, 0, 1, -8, 0, 1'b1);
      for (int r = 0; r < 3; r++) begin
         for (int c = 0; c < 3; c++) begin
            send_px(2, r*3 + c - 4,
                    (r == 2 || c == 2) ? 7 : c - r,
                    (r == 2 && c == 2) ? 7 : -8,
                    -(r*3 + c));
         end
      end
      drain("t4_drain");
      #1;
      check("t4_idle_valid", 32'(out_valid[2]), 0);
      @(negedge clk);

      // Next 3x3 frame all -2: starts cleanly at row 0 and shows the clamp.
      expect_px(2, ReluExp, ReluExp, ReluExp, ReluExp, 1'b1);
      for (int p = 0; p < 9; p++) send_px(2, -2, -2, -2, -2);
      drain("relu_drain");

      check("final_queue_empty", 32'(exp_q.size()), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/max_pool_stage.md
Name: max_pool_stage

Overview:
- 2x2, stride-2 max-pooling stage directly downstream of convolution_stage.
- Consumes the per-pixel, multi-beat channel stream that convolution_stage produces (ProcessingElements channels per beat, CyclesPerPixel beats per pixel, raster order).
- Emits pooled pixels in the same beat format at half resolution in each dimension.
- Holds one half-width row of partial maxima for all NumberOfK channels.

Parameters:
- NumberOfK, 4, total channels (kernels) per pixel
- BitSize, 4, data width per channel value, two's complement signed
- InWidth, 2, pixel width of the incoming feature map (conv output width)
- InHeight, 2, pixel height of the incoming feature map
- CyclesPerPixel, 2, beats per pixel
- ProcessingElements, (NumberOfK+CyclesPerPixel-1)/CyclesPerPixel, channels per beat (derived; do not override)

Ports:
- clk  in  1  clock
- res  in  1  reset; one clock; reset is synchronous and active-high
- in_valid  in  1  input beat valid
- in_ready  out  1  stage can accept a beat
- in_data  in  ProcessingElements*BitSize  channels for beat b = channels b*PE .. b*PE+PE-1
- out_valid  out  1  output beat valid
- out_ready  in  1  downstream accepts output beat
- out_data  out  ProcessingElements*BitSize  pooled channels, same beat layout
- out_done  out  1  high with the final output beat of a frame

Behaviour:
- Counters: beat (0..CPP-1), col (0..InWidth-1), row (0..InHeight-1).
  - Advance only on an input handshake (in_valid && in_ready).
  - beat wraps into col, col wraps into row, row wraps to 0 at frame end.
- Pair register: PE*BitSize, holds the even-column value of the current beat.
- Line buffer: InWidth/2 entries × NumberOfK channels × BitSize.
- Even row:
  - even col: store the beat into the pair register slot for that beat.
  - odd col: write max(pair, in) into line buffer entry col/2, channel slice for that beat.
- Odd row:
  - even col: pair = max(linebuf[col/2], in).
  - odd col: output = max(pair, in), registered into out_data.
- All max operations are signed, per channel, lane-wise; BitSize in = BitSize out; no widening.
- Unused lanes (when NumberOfK is not a multiple of PE) pass through max arithmetic unmodified; their value is don't-care.
- Floor semantics on odd dimensions:
  - Odd InWidth: last column beats are accepted and discarded.
  - Odd InHeight: last row beats are accepted and discarded (no output).
- Latency: an output beat appears on out_valid one cycle after the accepting input handshake of the matching odd-row/odd-col beat.
- Output register:
  - Loaded on a producing handshake.
  - out_valid held until out_ready.
  - in_ready = !out_valid || out_ready.
  - Simultaneous out drain and new load in one cycle is legal (full throughput).
- out_done:
  - Asserted with the last beat of the last pooled pixel (row InHeight-1 rounded down to odd, col likewise, beat CPP-1).
  - Held with that beat until it handshakes.
- Reset values: out_valid=0, out_done=0, out_data=0, counters=0, in_ready=1.
  - Line buffer and pair register are not reset; every read is preceded by a write.
- Reset mid-frame: counters and output register clear; partial frame is discarded; the next beat is treated as row0/col0/beat0.

Optional Feature:
- Macro: MAX_POOL_RELU_EN.
- Defined: each output lane is clamped to max(x,0); negative pooled results become 0.
- Undefined: signed max passed through unchanged.

Decomposition:
- Shared package cnn_pkg:
  - function for ProcessingElements = ceil(NumberOfK/CyclesPerPixel);
  - signed per-lane max function;
  - pixel beat typedef (PE × BitSize packed array);
  - reused by convolution_stage.
- One sub-module: pool_line_buffer. Single write and single read per cycle, addressed by {col/2, beat}, width PE*BitSize.

Test Plan:
- Single pixel pooling.
  - Config: InWidth=2, InHeight=2, NoK=4, CPP=2, BitSize=4.
  - Stimulus, channel0 over 4 pixels: 1, -3, 5, 2 -> out channel0 = 5, one pixel, 2 beats, out_done on beat 1.
- 4x4 map, channel-0 rows {1,2,3,4},{5,-1,0,7},{-8,-8,-2,-3},{-4,-5,-6,-1} -> pooled {5,7},{-4,-1}; out_done only on the final beat.
- Backpressure.
  - Same stimulus with out_ready low for 3 cycles on the first output.
  - Required: out_data stable, in_ready low, no beat lost, same results.
- Odd dims.
  - Config: InWidth=3, InHeight=3.
  - Required: exactly 1 output pixel = max of the top-left 2x2; column 2 and row 2 consumed, not output; counters back at 0.
- Reset mid-frame after 5 beats, then a full valid frame -> outputs match the clean-frame expectation; no spurious out_valid.
- MAX_POOL_RELU_EN: all inputs -2 -> outputs 0 (macro defined) versus -2 (macro undefined).
